// File: rtl/uart_echo_bridge.sv
// UART echo bridge: byte FIFO with pass-through or line-buffered release.
// Optional drop statistics port enabled by macro UART_ECHO_DROP_STATS_EN.
module uart_echo_bridge #(
    parameter int                    DATA_WIDTH = 8,
    parameter int                    DEPTH      = 16,
    parameter logic [DATA_WIDTH-1:0] TERM_CHAR  = 8'h0D
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    line_mode_i,
    input  logic [DATA_WIDTH-1:0]   s_axis_tdata,
    input  logic                    s_axis_tvalid,
    output logic                    s_axis_tready,
    input  logic                    frame_error_i,
    output logic [DATA_WIDTH-1:0]   m_axis_tdata,
    output logic                    m_axis_tvalid,
    input  logic                    m_axis_tready,
    output logic [$clog2(DEPTH):0]  level_o
`ifdef UART_ECHO_DROP_STATS_EN
    ,
    output logic [15:0]             drop_count_o
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    typedef enum logic {
        PASS,
        LINE
    } mode_t;

    mode_t state, state_nxt;

    logic [AW:0] wr_ptr, rd_ptr, cm_ptr;
    logic [AW:0] wr_nxt, rd_nxt, cm_nxt;
    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic push, pop, drop, full, line_commit;

    assign level_o       = wr_ptr - rd_ptr;
    assign full          = (level_o == FULL);
    assign push          = s_axis_tvalid && !frame_error_i && !full;
    assign drop          = s_axis_tvalid && (frame_error_i || full);
    assign pop           = m_axis_tvalid && m_axis_tready;
    assign s_axis_tready = !rst;
    assign m_axis_tvalid = (rd_ptr != cm_ptr);
    assign m_axis_tdata  = m_axis_tvalid ? mem[rd_ptr[AW-1:0]] : '0;

    always_comb begin
        state_nxt   = line_mode_i ? LINE : PASS;
        wr_nxt      = wr_ptr + (AW+1)'(push);
        rd_nxt      = rd_ptr + (AW+1)'(pop);
        cm_nxt      = cm_ptr;
        // A full buffer of uncommitted bytes is released to avoid deadlock
        line_commit = push &&
                      ((s_axis_tdata == TERM_CHAR) || (wr_nxt - rd_nxt == FULL));
        unique case (state)
            PASS: begin
                if (!line_mode_i || line_commit) cm_nxt = wr_nxt;
            end
            LINE: begin
                if (!line_mode_i || line_commit) cm_nxt = wr_nxt;
            end
            default: cm_nxt = cm_ptr;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= PASS;
            wr_ptr <= '0;
            rd_ptr <= '0;
            cm_ptr <= '0;
        end else begin
            state  <= state_nxt;
            wr_ptr <= wr_nxt;
            rd_ptr <= rd_nxt;
            cm_ptr <= cm_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && push) mem[wr_ptr[AW-1:0]] <= s_axis_tdata;
    end

`ifdef UART_ECHO_DROP_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            drop_count_o <= '0;
        end else if (drop && drop_count_o != 16'hFFFF) begin
            drop_count_o <= drop_count_o + 16'd1;
        end
    end
`else
    logic unused_drop;
    assign unused_drop = drop;
`endif

endmodule
